// File: rtl/gbdt_round_sequencer_if.sv
// Control bundle between the job/DMA front end, the class engines and the
// GBDT round sequencer. The sequencer takes the slave side.
interface gbdt_round_sequencer_if #(
  parameter int LANES  = 8,
  parameter int ROUNDS = 4
);
  localparam int RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

  logic                      start;
  logic                      abort;
  logic                      dma_valid;
  logic [LANES*ROUNDS-1:0]   used_classes;
  logic [LANES-1:0]          dones;
  logic                      max_done;
  logic [LANES:0]            enables;
  logic [RW-1:0]             round;
  logic                      done;
  logic                      error;
  logic                      busy;
  logic                      we;
  logic                      oe;
  logic                      cs;

  modport master (
    output start, abort, dma_valid, used_classes, dones, max_done,
    input  enables, round, done, error, busy, we, oe, cs
  );

  modport slave (
    input  start, abort, dma_valid, used_classes, dones, max_done,
    output enables, round, done, error, busy, we, oe, cs
  );
endinterface

// File: rtl/gbdt_round_sequencer.sv
// Round sequencer for the GBDT inference core: counts DMA beats, then runs
// lane-masked class-engine rounds, each followed by a MAX reduction.
module gbdt_round_sequencer #(
  parameter int LANES      = 8,
  parameter int ROUNDS     = 4,
  parameter int CYCLES_NUM = 2304,
  parameter int CONTIGUOUS = 1,
  parameter int TIMEOUT    = 4096
) (
  input  logic                  gbdt_clk,
  input  logic                  gbdt_rst_n,
  gbdt_round_sequencer_if.slave seq
);
  localparam int RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam int CW = $clog2(CYCLES_NUM + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_RUN, S_REDUCE, S_FINISH, S_FAIL
  } state_t;

  state_t                       state, state_nx;
  logic [RW-1:0]                r_idx, r_idx_nx, r_inc;
  logic [CW-1:0]                beat_cnt, beat_nx;
  logic [TW-1:0]                wd_cnt, wd_nx;
  logic [ROUNDS-1:0][LANES-1:0] slices;
  logic [LANES-1:0]             cur_slice;
  logic                         run_exit, wd_expire, last_round, next_lead, beat_last;

  assign slices     = seq.used_classes;
  assign cur_slice  = slices[r_idx];
  assign r_inc      = r_idx + 1'b1;
  assign last_round = (r_idx == RW'(ROUNDS - 1));
  assign next_lead  = slices[r_inc][0];
  // Masked-off lanes count as done, so only enabled engines can stall a round.
  assign run_exit   = &(seq.dones | ~cur_slice);
  assign wd_expire  = (wd_cnt >= TW'(TIMEOUT - 1));
  assign beat_last  = seq.dma_valid && (beat_cnt == CW'(CYCLES_NUM - 1));

  always_ff @(posedge gbdt_clk or negedge gbdt_rst_n) begin
    if (!gbdt_rst_n) begin
      state    <= S_IDLE;
      r_idx    <= '0;
      beat_cnt <= '0;
      wd_cnt   <= '0;
    end else begin
      state    <= state_nx;
      r_idx    <= r_idx_nx;
      beat_cnt <= beat_nx;
      wd_cnt   <= wd_nx;
    end
  end

  always_comb begin
    state_nx = state;
    r_idx_nx = r_idx;
    beat_nx  = '0;
    wd_nx    = '0;
    case (state)
      S_IDLE: if (seq.start) begin
        state_nx = S_LOAD;
        r_idx_nx = '0;
      end
      S_LOAD: begin
        if (beat_last)              state_nx = S_SETTLE;
        else if (seq.dma_valid)     beat_nx  = beat_cnt + 1'b1;
        else if (CONTIGUOUS == 0)   beat_nx  = beat_cnt;
      end
      S_SETTLE: state_nx = S_RUN;
      S_RUN: begin
        wd_nx = wd_cnt + 1'b1;
        if (run_exit)       state_nx = S_REDUCE;
        else if (wd_expire) state_nx = S_FAIL;
      end
      S_REDUCE: begin
        wd_nx = wd_cnt + 1'b1;
        if (seq.max_done) begin
          if (!last_round && next_lead) begin
            state_nx = S_SETTLE;
            r_idx_nx = r_inc;
          end else begin
            state_nx = S_FINISH;
          end
        end else if (wd_expire) begin
          state_nx = S_FAIL;
        end
      end
      default: state_nx = S_IDLE;
    endcase
    // Abort overrides everything and must not leave a stale count for the next job.
    if (seq.abort && state != S_IDLE && state != S_FAIL) begin
      state_nx = S_FAIL;
      beat_nx  = '0;
      wd_nx    = '0;
    end
  end

  always_comb begin
    seq.we      = 1'b0;
    seq.oe      = 1'b0;
    seq.cs      = 1'b0;
    seq.done    = 1'b0;
    seq.error   = 1'b0;
    seq.round   = '0;
    seq.enables = '0;
    seq.busy    = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        seq.we = 1'b1;
        seq.cs = 1'b1;
      end
      S_LOAD:   seq.cs = 1'b1;
      S_SETTLE: seq.round = r_idx;
      S_RUN: begin
        seq.cs      = 1'b1;
        seq.oe      = 1'b1;
        seq.round   = r_idx;
        seq.enables = {cur_slice, 1'b0};
      end
      S_REDUCE: begin
        seq.round   = r_idx;
        seq.enables = {{LANES{1'b0}}, 1'b1};
      end
      // A same-cycle abort wins over completion.
      S_FINISH: seq.done  = ~seq.abort;
      S_FAIL:   seq.error = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_gbdt_round_sequencer.sv
// Bench for gbdt_round_sequencer: builds an expected per-cycle trace for each
// job from the job description, then replays stimulus and compares outputs.
module tb_gbdt_round_sequencer;
  localparam int LANES = 8, ROUNDS = 4, CN = 16, TO = 32;

  logic gbdt_clk = 1'b0;
  logic gbdt_rst_n;
  always #5 gbdt_clk = ~gbdt_clk;

  gbdt_round_sequencer_if #(.LANES(LANES), .ROUNDS(ROUNDS)) ia ();
  gbdt_round_sequencer_if #(.LANES(LANES), .ROUNDS(ROUNDS)) ib ();

  gbdt_round_sequencer #(.LANES(LANES), .ROUNDS(ROUNDS), .CYCLES_NUM(CN),
                         .CONTIGUOUS(1), .TIMEOUT(TO))
    dut_a (.gbdt_clk(gbdt_clk), .gbdt_rst_n(gbdt_rst_n), .seq(ia.slave));
  gbdt_round_sequencer #(.LANES(LANES), .ROUNDS(ROUNDS), .CYCLES_NUM(CN),
                         .CONTIGUOUS(0), .TIMEOUT(TO))
    dut_b (.gbdt_clk(gbdt_clk), .gbdt_rst_n(gbdt_rst_n), .seq(ib.slave));

  // Output vector: {we, oe, cs, busy, done, error, round[1:0], enables[8:0]}
  localparam logic [16:0] O_IDLE   = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 9'h000};
  localparam logic [16:0] O_LOAD   = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 9'h000};
  localparam logic [16:0] O_FINISH = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 9'h000};
  localparam logic [16:0] O_FAIL   = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 9'h000};

  int checks = 0, passed = 0, fails = 0;
  logic [31:0] mask;
  int          lane_lat [ROUNDS][LANES];
  int          max_lat  [ROUNDS];
  bit          dma [$];
  logic [11:0] in_q [$];   // {start, abort, dma_valid, dones[7:0], max_done}
  logic [16:0] exp_q [$];

  function automatic logic [16:0] o_settle(input int r);
    return {3'b000, 1'b1, 2'b00, 2'(r), 9'h000};
  endfunction
  function automatic logic [16:0] o_run(input int r, input logic [7:0] sl);
    return {1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 2'(r), sl, 1'b0};
  endfunction
  function automatic logic [16:0] o_reduce(input int r);
    return {3'b000, 1'b1, 2'b00, 2'(r), 9'h001};
  endfunction
  function automatic logic [11:0] iv(input logic s, input logic a, input logic v,
                                     input logic [7:0] d, input logic m);
    return {s, a, v, d, m};
  endfunction
  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic [11:0] i, input logic [16:0] o);
    in_q.push_back(i);
    exp_q.push_back(o);
  endtask
  task automatic push_idle();
    push(iv(1'b0, rb(), rb(), 8'($urandom), rb()), O_IDLE);
  endtask
  task automatic push_fail();
    push(iv(rb(), 1'b0, 1'b0, 8'($urandom), rb()), O_FAIL);
    push_idle();
  endtask

  // Index of the DMA beat on which loading completes.
  function automatic int find_load_end(input bit contig);
    int seen = 0;
    for (int k = 0; k < dma.size(); k++) begin
      if (contig) begin
        if (k + 1 >= CN) begin
          bit all_ones = 1'b1;
          for (int i = k - CN + 1; i <= k; i++) all_ones &= dma[i];
          if (all_ones) return k;
        end
      end else begin
        seen += int'(dma[k]);
        if (seen == CN) return k;
      end
    end
    return -1;
  endfunction

  task automatic build_job(input bit contig);
    int load_end, run_end, jt, r;
    logic [7:0] sl, dn;
    exp_q.delete();
    in_q.delete();
    push(iv(1'b1, 1'b0, 1'b0, 8'h00, 1'b0), O_IDLE);
    load_end = find_load_end(contig);
    for (int k = 0; k <= load_end; k++)
      push(iv(rb(), 1'b0, dma[k], 8'($urandom), rb()), O_LOAD);
    r = 0;
    for (int guard = 0; guard < ROUNDS; guard++) begin
      push(iv(rb(), 1'b0, 1'b0, 8'($urandom), rb()), o_settle(r));
      sl = mask[r*LANES +: LANES];
      run_end = 0;
      for (int l = 0; l < LANES; l++)
        if (sl[l] && lane_lat[r][l] > run_end) run_end = lane_lat[r][l];
      jt = 0;
      for (int j = 0; j < 100000; j++) begin
        for (int l = 0; l < LANES; l++)
          dn[l] = sl[l] ? (j >= lane_lat[r][l]) : rb();
        push(iv(rb(), 1'b0, 1'b0, dn, rb()), o_run(r, sl));
        jt++;
        if (j == run_end) break;
        if (jt >= TO) begin push_fail(); return; end
      end
      for (int j = 0; j < 100000; j++) begin
        push(iv(rb(), 1'b0, 1'b0, 8'($urandom), j >= max_lat[r]), o_reduce(r));
        jt++;
        if (j >= max_lat[r]) break;
        if (jt >= TO) begin push_fail(); return; end
      end
      if (r + 1 < ROUNDS && mask[(r+1)*LANES]) r++;
      else break;
    end
    push(iv(rb(), 1'b0, 1'b0, 8'($urandom), rb()), O_FINISH);
    push_idle();
  endtask

  task automatic inject_abort(input int at);
    logic [11:0] t;
    logic [16:0] e;
    while (exp_q.size() > at + 1) begin
      void'(exp_q.pop_back());
      void'(in_q.pop_back());
    end
    t = in_q[at];
    t[10] = 1'b1;
    in_q[at] = t;
    if (exp_q[at] == O_FINISH) begin
      e = exp_q[at];
      e[12] = 1'b0;
      exp_q[at] = e;
    end
    push_fail();
  endtask

  task automatic setup(input logic [31:0] m, input int lat, input int mlat);
    mask = m;
    for (int r = 0; r < ROUNDS; r++) begin
      max_lat[r] = mlat;
      for (int l = 0; l < LANES; l++) lane_lat[r][l] = lat;
    end
    dma.delete();
    for (int k = 0; k < CN; k++) dma.push_back(1'b1);
  endtask

  task automatic setup_random();
    for (int r = 0; r < ROUNDS; r++) begin
      mask[r*LANES +: LANES] = 8'($urandom);
      if ($urandom_range(0, 4) == 0) mask[r*LANES +: LANES] = 8'h00;
      max_lat[r] = int'($urandom_range(0, 3));
      for (int l = 0; l < LANES; l++) lane_lat[r][l] = int'($urandom_range(0, 4));
    end
    dma.delete();
    repeat ($urandom_range(0, 20)) dma.push_back($urandom_range(0, 9) < 8);
    for (int k = 0; k < CN; k++) dma.push_back(1'b1);
  endtask

  task automatic drive(input bit sel, input logic [11:0] v);
    if (!sel) begin
      {ia.start, ia.abort, ia.dma_valid, ia.dones, ia.max_done} = v;
      ia.used_classes = mask;
    end else begin
      {ib.start, ib.abort, ib.dma_valid, ib.dones, ib.max_done} = v;
      ib.used_classes = mask;
    end
  endtask

  task automatic sample(input bit sel, output logic [16:0] o);
    if (!sel) o = {ia.we, ia.oe, ia.cs, ia.busy, ia.done, ia.error, ia.round, ia.enables};
    else      o = {ib.we, ib.oe, ib.cs, ib.busy, ib.done, ib.error, ib.round, ib.enables};
  endtask

  task automatic check(input string tag, input int cyc, input logic [16:0] obs,
                       input logic [16:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else begin
      fails++;
      $error("FAIL %s cycle %0d: observed %h expected %h", tag, cyc, obs, expv);
    end
  endtask

  task automatic run_job(input bit sel, input string tag, input int last);
    int n;
    logic [16:0] o;
    n = exp_q.size();
    if (last >= 0 && last < n) n = last + 1;
    for (int c = 0; c < n; c++) begin
      @(posedge gbdt_clk);
      #1 drive(sel, in_q[c]);
      #1 sample(sel, o);
      check(tag, c, o, exp_q[c]);
    end
  endtask

  function automatic int first_where(input logic [16:0] sel_mask, input logic [16:0] val);
    for (int i = 0; i < exp_q.size(); i++)
      if ((exp_q[i] & sel_mask) == val) return i;
    return 0;
  endfunction

  initial begin
    logic [16:0] o;
    int at;
    int cand [$];
    mask = '0;
    drive(1'b0, 12'h000);
    drive(1'b1, 12'h000);
    gbdt_rst_n = 1'b0;
    #2 sample(1'b0, o); check("reset_a", 0, o, O_IDLE);
    sample(1'b1, o);    check("reset_b", 0, o, O_IDLE);
    repeat (2) @(posedge gbdt_clk);
    #3 gbdt_rst_n = 1'b1;

    setup(32'h0000_00FF, 0, 0);
    build_job(1'b1);
    run_job(1'b0, "single_round", -1);

    setup(32'h0105_0101, 3, 1);
    build_job(1'b1);
    run_job(1'b0, "four_rounds", -1);

    setup(32'h0000_00FF, 0, 0);
    dma.delete();
    repeat (10) dma.push_back(1'b1);
    dma.push_back(1'b0);
    repeat (16) dma.push_back(1'b1);
    build_job(1'b1);
    run_job(1'b0, "gap_contig", -1);
    build_job(1'b0);
    run_job(1'b1, "gap_hold", -1);

    setup(32'h0101_0101, 3, 1);
    build_job(1'b1);
    at = first_where({4'b0100, 2'b00, 2'b11, 9'h000}, {4'b0100, 2'b00, 2'b10, 9'h000});
    inject_abort(at + 1);
    run_job(1'b0, "abort_run2", -1);
    setup(32'h0000_0303, 1, 1);
    build_job(1'b1);
    run_job(1'b0, "after_abort", -1);

    setup(32'h0000_00FF, 0, 0);
    lane_lat[0][3] = 1000;
    build_job(1'b1);
    run_job(1'b0, "watchdog", -1);
    build_job(1'b1);
    inject_abort(exp_q.size() - 3);
    run_job(1'b0, "watchdog_abort", -1);

    setup(32'h0000_0303, 1, 2);
    build_job(1'b1);
    run_job(1'b0, "pre_reset", first_where(17'h1FFFF & {4'b0001, 2'b00, 2'b00, 9'h1FF},
                                            {4'b0001, 2'b00, 2'b00, 9'h001}));
    #1 gbdt_rst_n = 1'b0;
    #1 sample(1'b0, o); check("reset_in_reduce", 0, o, O_IDLE);
    drive(1'b0, 12'h000);
    @(posedge gbdt_clk);
    #3 gbdt_rst_n = 1'b1;

    for (int j = 0; j < 24; j++) begin
      bit sel;
      sel = rb();
      setup_random();
      build_job(!sel);
      if ($urandom_range(0, 3) == 0) begin
        cand.delete();
        for (int i = 1; i < exp_q.size(); i++)
          if (exp_q[i][13] && !exp_q[i][11]) cand.push_back(i);
        inject_abort(cand[$urandom_range(0, cand.size() - 1)]);
      end
      run_job(sel, sel ? "random_hold" : "random_contig", -1);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/gbdt_round_sequencer.md
# gbdt_round_sequencer

Parametrised control FSM for the GBDT inference core; successor to the fixed 8-lane / 4-round controller. It counts incoming DMA feature beats, then sequences up to ROUNDS rounds of per-class tree evaluation (LANES class engines per round) and a MAX-reduction step after each round. Compared with the fixed controller it adds three things: a lane-masked completion check, a synchronous abort, and a per-round watchdog with an error pulse. It sits between the top-level DMA/start logic and the class engines, MAX unit and weight SRAM.

## Interface
- LANES, 8, class engines per round.
- ROUNDS, 4, maximum rounds; RW = max(1,$clog2(ROUNDS)).
- CYCLES_NUM, 2304, DMA beats per input vector (≥2); CW = $clog2(CYCLES_NUM+1).
- CONTIGUOUS, 1, 1: a dma_valid gap clears the beat count; 0: a gap holds the count.
- TIMEOUT, 4096, maximum cycles allowed in RUN+REDUCE of one round (≥2); TW = $clog2(TIMEOUT+1).
- gbdt_clk  in  1  clock; one clock domain.
- gbdt_rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a job; sampled only in IDLE.
- abort  in  1  synchronous cancel; effective in any state except IDLE.
- dma_valid  in  1  one input beat accepted per high cycle in LOAD.
- used_classes  in  LANES*ROUNDS  lane-use mask; slice r is [r*LANES +: LANES]; must be stable from start until done or error.
- dones  in  LANES  per-engine done.
- max_done  in  1  MAX unit done.
- enables  out  LANES+1  [LANES:1] engine enables, [0] MAX enable.
- round  out  RW  current round index.
- done  out  1  one-cycle pulse on successful completion.
- error  out  1  one-cycle pulse on abort or watchdog expiry.
- busy  out  1  high in every state except IDLE.
- we, oe, cs  out  1  SRAM controls.

## Operation
- States: IDLE, LOAD, SETTLE, RUN, REDUCE, FINISH, FAIL. Registered state r_idx (RW bits), beat counter (CW bits), watchdog counter (TW bits). Outputs are a combinational decode of these registers.
- IDLE: we=1, cs=1. On start go to LOAD and clear r_idx to 0.
- LOAD: cs=1. The counter increments on dma_valid. On a no-valid cycle it clears to 0 if CONTIGUOUS=1, otherwise it holds. Exit to SETTLE in the same cycle the CYCLES_NUM-th counted beat is accepted.
- SETTLE: drives round=r_idx, all enables 0, and clears the watchdog. Lasts exactly 1 cycle, then goes to RUN. This cycle blocks stale dones from the previous round.
- RUN: cs=1, oe=1, enables={slice(r_idx),1'b0}. Exit to REDUCE when &(dones | ~slice(r_idx)), i.e. only enabled lanes must report done. An all-zero slice therefore exits after exactly 1 RUN cycle.
- REDUCE: enables = 1 (MAX only). When max_done is high:
  - go to SETTLE with r_idx+1 if r_idx+1 < ROUNDS and used_classes[(r_idx+1)*LANES] = 1;
  - otherwise go to FINISH.
- FINISH: done=1 for 1 cycle, then IDLE.
- FAIL: error=1 for 1 cycle, then IDLE.
- round = r_idx in SETTLE, RUN and REDUCE; 0 in all other states.
- Watchdog: increments every cycle in RUN and REDUCE. When it reaches TIMEOUT with no exit condition met, go to FAIL.
- Priority, highest first: abort > watchdog expiry > normal transition. abort in FINISH still goes to FAIL, and done is suppressed.
- start outside IDLE is ignored. abort in IDLE is ignored.

## Timing
- Reset (async assert): state=IDLE, r_idx=0, all counters 0. Outputs during reset: we=1, cs=1, all others 0.
- Deassertion is assumed synchronised upstream.
- The start → LOAD transition takes 1 cycle.
- Minimum job (1 round, contiguous DMA, dones and max_done already high):
  - start cycle + CYCLES_NUM LOAD cycles + SETTLE + RUN + REDUCE + FINISH;
  - done is asserted CYCLES_NUM+4 cycles after the start cycle.
- Each extra round adds 3 cycles minimum (SETTLE, RUN, REDUCE).
- abort sampled high in cycle n: FAIL is the state in n+1 and error is high in n+1; busy drops in n+2.
- Watchdog expiry: FAIL is entered after exactly TIMEOUT cycles spent in RUN+REDUCE of one round.
- Reset asserted mid-job: immediate return to IDLE. Neither done nor error is pulsed.

## Test plan
- Single round: LANES=8, ROUNDS=4, CYCLES_NUM=16, used_classes=32'h0000_00FF, contiguous beats, dones=8'hFF, max_done=1 → round stays 0, enables=9'h1FE then 9'h001, done 20 cycles after start, error 0.
- Four rounds: used_classes=32'h0105_0101, engines answer after 3 cycles → round sequence 0,1,2,3; RUN enables are {slice,0}; masked lanes (dones=0) do not stall; one done pulse.
- DMA gap: CONTIGUOUS=1, 10 beats, one gap, 16 beats → LOAD exits only after the final 16 contiguous beats. CONTIGUOUS=0 with the same stimulus → LOAD exits at the 16th total beat.
- Abort mid-RUN in round 2 → next cycle state=FAIL and error=1; then IDLE with busy=0 and enables=0. A following start runs normally.
- Watchdog: TIMEOUT=32, one enabled lane never done → error exactly 32 cycles after RUN entry, no done pulse. abort and expiry in the same cycle → a single error pulse.
- Reset asserted in REDUCE → outputs immediately we=1, cs=1, others 0. start ignored while busy.
